hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core (fetch, decode, execute, memory, write-back). It generates the core-wide stall and flush controls and inserts a bubble on load-use hazards. It redirects the PC on taken branches and jumps, and freezes the pipe while the data memory has not acknowledged a request. Its `hc_o_stall` and `hc_o_flush` outputs drive the datapath's stall and flush inputs; its hazard inputs are tapped from the decode, execute and memory stages.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding is fixed so other tools can decode it from waveforms.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hc_state_e;

  localparam int STALL_CNT_WIDTH = 32;
  localparam int WAIT_CNT_WIDTH  = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(&cnt)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect flushes,
// memory-wait freezes, plus stall accounting and a sticky timeout.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 15
) (
  input  logic                hc_clk,
  input  logic                hc_rst,
  input  logic                hc_i_ce,
  input  logic                hc_i_stall,
  input  logic                hc_i_de_valid,
  input  logic [AWIDTH-1:0]   hc_i_de_rs1_addr,
  input  logic [AWIDTH-1:0]   hc_i_de_rs2_addr,
  input  logic                hc_i_ex_valid,
  input  logic                hc_i_ex_is_load,
  input  logic [AWIDTH-1:0]   hc_i_ex_rd_addr,
  input  logic                hc_i_change_pc,
  input  logic [PC_WIDTH-1:0] hc_i_next_pc,
  input  logic                hc_i_mem_req,
  input  logic                hc_i_mem_ack,
  output logic                hc_o_stall,
  output logic                hc_o_bubble,
  output logic                hc_o_flush,
  output logic                hc_o_pc_load,
  output logic [PC_WIDTH-1:0] hc_o_pc,
  output logic                hc_o_timeout,
  output logic [31:0]         hc_o_stall_cnt
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
  localparam logic [WAIT_CNT_WIDTH-1:0] MW = WAIT_CNT_WIDTH'(MAX_WAIT);

  hc_state_e state;
  hc_state_e nstate;
  logic [2:0] fcnt;
  logic [WAIT_CNT_WIDTH-1:0] wcnt;
  logic load_use;
  logic mem_wait;
  logic on;
  logic act;
  logic hold;
  logic take_pc;
  logic to_set;

  assign load_use = hc_i_de_valid & hc_i_ex_valid & hc_i_ex_is_load
                  & (hc_i_ex_rd_addr != '0)
                  & ((hc_i_ex_rd_addr == hc_i_de_rs1_addr)
                   | (hc_i_ex_rd_addr == hc_i_de_rs2_addr));
  assign mem_wait = hc_i_mem_req & ~hc_i_mem_ack;

  // on: outputs live; act: state may advance
  assign on  = hc_i_ce & hc_rst;
  assign act = on & ~hc_i_stall;

  always_comb begin
    nstate  = state;
    hold    = 1'b0;
    take_pc = 1'b0;
    to_set  = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          hold   = 1'b1;
          nstate = MEM_WAIT;
        end else if (hc_i_change_pc) begin
          take_pc = 1'b1;
          nstate  = FLUSH;
        end else if (load_use) begin
          hold   = 1'b1;
          nstate = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        hold   = mem_wait;
        nstate = mem_wait ? MEM_WAIT : RUN;
      end
      FLUSH: begin
        if (mem_wait) begin
          hold = 1'b1;
        end else if (fcnt == 3'd1) begin
          nstate = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          nstate = RUN;
        end else if (wcnt == MW) begin
          to_set = 1'b1;
          nstate = RUN;
        end else begin
          hold = 1'b1;
        end
      end
      default: nstate = RUN;
    endcase
  end

  always_ff @(posedge hc_clk) begin
    if (!hc_rst) begin
      state        <= RUN;
      fcnt         <= '0;
      hc_o_pc      <= '0;
      hc_o_timeout <= 1'b0;
    end else if (act) begin
      state <= nstate;
      if (take_pc) begin
        hc_o_pc <= hc_i_next_pc;
        fcnt    <= FC;
      end else if (state == FLUSH && !mem_wait) begin
        fcnt <= fcnt - 3'd1;
      end
      if (to_set) hc_o_timeout <= 1'b1;
    end
  end

  assign hc_o_stall   = on & (hc_i_stall | hold);
  assign hc_o_bubble  = on & (state == LOAD_STALL);
  assign hc_o_flush   = on & (state == FLUSH);
  // counter untouched until the first unstalled flush cycle
  assign hc_o_pc_load = on & (state == FLUSH)
                      & (fcnt == FC) & ~hc_o_stall;

  sat_counter #(
    .WIDTH(WAIT_CNT_WIDTH)
  ) u_wait_cnt (
    .clk  (hc_clk),
    .rst_n(hc_rst),
    .en   (act & (nstate == MEM_WAIT)),
    .clr  (act & (nstate != MEM_WAIT)),
    .cnt  (wcnt)
  );

  sat_counter #(
    .WIDTH(STALL_CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (hc_clk),
    .rst_n(hc_rst),
    .en   (hc_o_stall),
    .clr  (1'b0),
    .cnt  (hc_o_stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MAX_WAIT     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        ext_stall;
  logic        de_valid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        ex_valid;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        cp;
  logic [31:0] npc;
  logic        req;
  logic        ack;
  logic        stall;
  logic        bubble;
  logic        flush;
  logic        pc_load;
  logic [31:0] pc;
  logic        timeout;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .AWIDTH      (5),
    .PC_WIDTH    (32),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .MAX_WAIT    (MAX_WAIT)
  ) dut (
    .hc_clk          (clk),
    .hc_rst          (rst),
    .hc_i_ce         (ce),
    .hc_i_stall      (ext_stall),
    .hc_i_de_valid   (de_valid),
    .hc_i_de_rs1_addr(rs1),
    .hc_i_de_rs2_addr(rs2),
    .hc_i_ex_valid   (ex_valid),
    .hc_i_ex_is_load (ex_load),
    .hc_i_ex_rd_addr (ex_rd),
    .hc_i_change_pc  (cp),
    .hc_i_next_pc    (npc),
    .hc_i_mem_req    (req),
    .hc_i_mem_ack    (ack),
    .hc_o_stall      (stall),
    .hc_o_bubble     (bubble),
    .hc_o_flush      (flush),
    .hc_o_pc_load    (pc_load),
    .hc_o_pc         (pc),
    .hc_o_timeout    (timeout),
    .hc_o_stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc;
    logic        timeout;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // model: what the pipe still owes, not how it is encoded
  int          flush_left = 0;
  bit          pc_due     = 0;
  bit          bubble_now = 0;
  bit          waiting    = 0;
  int          waited     = 0;
  logic [31:0] m_pc       = '0;
  bit          m_to       = 0;
  logic [31:0] m_cnt      = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",     32'(stall),   32'(e.stall));
      chk("bubble",    32'(bubble),  32'(e.bubble));
      chk("flush",     32'(flush),   32'(e.flush));
      chk("pc_load",   32'(pc_load), 32'(e.pc_load));
      chk("pc",        pc,           e.pc);
      chk("timeout",   32'(timeout), 32'(e.timeout));
      chk("stall_cnt", stall_cnt,    e.cnt);
    end
  end

  task automatic step();
    exp_t e;
    bit on, lu, mw, want;
    on = ce && rst;
    lu = de_valid && ex_valid && ex_load && ex_rd != 0
      && (ex_rd == rs1 || ex_rd == rs2);
    mw = req && !ack;
    want = 0;
    e.bubble = 0;
    e.flush = 0;
    e.pc_load = 0;
    if (bubble_now) begin
      want = mw;
      e.bubble = on;
    end else if (flush_left > 0) begin
      want = mw;
      e.flush = on;
    end else if (waiting) begin
      want = mw && waited < MAX_WAIT;
    end else begin
      want = mw || (!cp && lu);
    end
    e.stall = on && (ext_stall || want);
    if (flush_left > 0 && !bubble_now)
      e.pc_load = on && pc_due && !e.stall;
    e.pc = m_pc;
    e.timeout = m_to;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) begin
      flush_left = 0; pc_due = 0; bubble_now = 0;
      waiting = 0; waited = 0; m_pc = '0; m_to = 0; m_cnt = '0;
    end else if (on) begin
      if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (!ext_stall) begin
        if (bubble_now) begin
          bubble_now = 0;
          if (mw) begin waiting = 1; waited = 1; end
        end else if (flush_left > 0) begin
          if (!mw) begin pc_due = 0; flush_left--; end
        end else if (waiting) begin
          if (!mw) waiting = 0;
          else if (waited >= MAX_WAIT) begin waiting = 0; m_to = 1; end
          else waited++;
        end else if (mw) begin
          waiting = 1; waited = 1;
        end else if (cp) begin
          m_pc = npc; flush_left = FLUSH_CYCLES; pc_due = 1;
        end else if (lu) begin
          bubble_now = 1;
        end
      end
    end
  endtask

  task automatic idle();
    rst = 1; ce = 1; ext_stall = 0; de_valid = 0; rs1 = 0; rs2 = 0;
    ex_valid = 0; ex_load = 0; ex_rd = 0; cp = 0; npc = 0;
    req = 0; ack = 0;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    idle();
    steps(2);
    // load-use on rs2
    de_valid = 1; rs1 = 3; rs2 = 5;
    ex_valid = 1; ex_load = 1; ex_rd = 5;
    step();
    idle(); steps(2);
    // redirect, with a wrong-path redirect during flush
    cp = 1; npc = 32'h80; step();
    npc = 32'h100; step();
    cp = 0; steps(3);
    // memory wait, ack on the fourth cycle
    req = 1; steps(3);
    ack = 1; step();
    idle(); step();
    // all three hazards together
    req = 1; cp = 1; npc = 32'h200;
    de_valid = 1; rs1 = 7; ex_valid = 1; ex_load = 1; ex_rd = 7;
    step();
    idle(); req = 1; ack = 1; step();
    idle(); steps(2);
    // external freeze at flush start
    cp = 1; npc = 32'h44; step();
    cp = 0; ext_stall = 1; steps(4);
    ext_stall = 0; steps(3);
    // reset mid memory wait
    req = 1; steps(2);
    rst = 0; step();
    idle(); steps(2);
    // reset mid flush
    cp = 1; npc = 32'hC0; step();
    cp = 0; rst = 0; step();
    idle(); steps(2);
    // enable low mid flush
    cp = 1; npc = 32'h18; step();
    cp = 0; ce = 0; steps(2);
    ce = 1; steps(3);
    // timeout
    req = 1; steps(MAX_WAIT + 3);
    idle(); steps(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) >= 2);
      ce        = ($urandom_range(99) >= 8);
      ext_stall = ($urandom_range(99) < 10);
      de_valid  = ($urandom_range(99) < 70);
      rs1       = 5'($urandom_range(7));
      rs2       = 5'($urandom_range(7));
      ex_valid  = ($urandom_range(99) < 70);
      ex_load   = ($urandom_range(99) < 40);
      ex_rd     = 5'($urandom_range(7));
      cp        = ($urandom_range(99) < 15);
      npc       = $urandom;
      req       = ($urandom_range(99) < 25);
      ack       = ($urandom_range(99) < 40);
      step();
    end
    idle();
    steps(2);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
